// File: rtl/flag_pkg.sv
// Shared constants and helpers for the condition-flag register and its save stack.
package flag_pkg;

   localparam int FLAG_Z            = 0;
   localparam int FLAG_V            = 1;
   localparam int FLAG_N            = 2;
   localparam int DEFAULT_NUM_FLAGS = 3;

   // Bits needed to hold values 0..n-1 (callers pass STACK_DEPTH+1).
   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/flag_stack.sv
// LIFO save/restore storage for flag snapshots; push/pop arrive already qualified.
module flag_stack
   import flag_pkg::*;
#(
   parameter  int WIDTH       = DEFAULT_NUM_FLAGS,
   parameter  int STACK_DEPTH = 4,
   localparam int DW          = clog2(STACK_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic [DW-1:0]    depth,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] stack_q [STACK_DEPTH];
   logic [DW-1:0]    depth_q;
   logic [DW-1:0]    depth_d;

   always_comb begin
      depth_d = depth_q;
      if (push)
         depth_d = depth_q + DW'(1);
      else if (pop)
         depth_d = depth_q - DW'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         depth_q <= '0;
      else
         depth_q <= depth_d;
   end

   // NOTE: storage has no reset; entries at or above depth are never read.
   always_ff @(posedge clk) begin
      if (push) begin
         for (int i = 0; i < STACK_DEPTH; i++) begin
            if (DW'(i) == depth_q)
               stack_q[i] <= wr_data;
         end
      end
   end

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
         if (DW'(i + 1) == depth_q)
            rd_data = stack_q[i];
      end
   end

   assign depth = depth_q;
   assign full  = (depth_q == DW'(STACK_DEPTH));
   assign empty = (depth_q == '0);

endmodule

// File: rtl/flag_file.sv
// Condition-flag register with per-bit write enables, sticky bits, a save/restore
// stack and a sticky error for stack misuse.
module flag_file
   import flag_pkg::*;
#(
   parameter  int                   NUM_FLAGS   = DEFAULT_NUM_FLAGS,
   parameter  int                   STACK_DEPTH = 4,
   parameter  logic [NUM_FLAGS-1:0] STICKY_MASK = '0,
   localparam int                   DW          = clog2(STACK_DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_FLAGS-1:0] write,
   input  logic [NUM_FLAGS-1:0] in,
   input  logic                 push,
   input  logic                 pop,
   input  logic                 clr_sticky,
   input  logic                 clr_err,
   output logic [NUM_FLAGS-1:0] flag_out,
   output logic [DW-1:0]        depth,
   output logic                 full,
   output logic                 empty,
   output logic                 err
);

   logic [NUM_FLAGS-1:0] flag_q, flag_d;
   logic                 err_q, err_d;
   logic [NUM_FLAGS-1:0] stack_top;
   logic                 push_ok, pop_ok, err_event;

   assign push_ok   = push & ~pop & ~full;
   assign pop_ok    = pop & ~push & ~empty;
   assign err_event = (push & pop) | (push & ~pop & full) | (pop & ~push & empty);

   flag_stack #(
      .WIDTH       (NUM_FLAGS),
      .STACK_DEPTH (STACK_DEPTH)
   ) u_stack (
      .clk     (clk),
      .rst     (rst),
      .push    (push_ok),
      .pop     (pop_ok),
      .wr_data (flag_q),
      .rd_data (stack_top),
      .depth   (depth),
      .full    (full),
      .empty   (empty)
   );

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      flag_d = flag_q;
      for (int i = 0; i < NUM_FLAGS; i++) begin
         if (STICKY_MASK[i])
            flag_d[i] = (clr_sticky ? 1'b0 : flag_q[i]) | (write[i] & in[i]);
         else if (write[i])
            flag_d[i] = in[i];
      end
      // A restore overrides whatever write/clear produced this cycle.
      if (pop_ok)
         flag_d = stack_top;

      err_d = err_event | (err_q & ~clr_err);
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         flag_q <= '0;
         err_q  <= 1'b0;
      end else begin
         flag_q <= flag_d;
         err_q  <= err_d;
      end
   end

   assign flag_out = flag_q;
   assign err      = err_q;

endmodule

// File: doc/flag_file.md
Name: flag_file

Overview:
- Parametrised successor to the 3-bit N/V/Z flag register.
- Holds NUM_FLAGS condition flags, each with its own write enable.
- Flags can be marked sticky: they accumulate sets until explicitly cleared.
- A LIFO save/restore stack of depth STACK_DEPTH saves flags on interrupt/call entry and restores them on return.
- Sits between the ALU flag outputs and the branch-condition logic in the execute/memory stages.

Parameters:
- NUM_FLAGS, 3: number of flag bits (bit2=N, bit1=V, bit0=Z at default).
- STACK_DEPTH, 4: number of save/restore entries (≥1).
- STICKY_MASK, 0 (NUM_FLAGS bits): bit i=1 makes flag i sticky.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- write  in  NUM_FLAGS  per-flag write enable.
- in  in  NUM_FLAGS  new flag values.
- push  in  1  save current flags to stack.
- pop  in  1  restore flags from stack top.
- clr_sticky  in  1  clear all sticky flags.
- clr_err  in  1  clear err.
- flag_out  out  NUM_FLAGS  registered flag values.
- depth  out  $clog2(STACK_DEPTH+1)  number of occupied stack entries.
- full  out  1  depth==STACK_DEPTH.
- empty  out  1  depth==0.
- err  out  1  sticky overflow/underflow/conflict error.

Behaviour:
- Reset (rst=0, asynchronous): flag_out=0, depth=0, empty=1, full=0, err=0. Stack contents are don't-care. Reset mid-push/pop discards the operation.
- All state updates on the rising clk edge. flag_out changes one cycle after the inputs; no combinational path from inputs to flag_out.
- Non-sticky flag i: next = write[i] ? in[i] : flag_out[i].
- Sticky flag i:
  - next = (clr_sticky ? 0 : flag_out[i]) | (write[i] & in[i]).
  - A write of 0 never clears a sticky flag.
  - A write of 1 in the same cycle as clr_sticky leaves the flag set.
- Clear/write/pop ordering: clr_sticky and write are applied first; a valid pop then overrides all flags.
- Push (push=1, pop=0, full=0):
  - stack[depth] <= flag_out, the pre-write value.
  - depth+1.
  - write/clr_sticky still update flag_out the same cycle, so the saved value is the old flags.
- Pop (pop=1, push=0, empty=0):
  - flag_out <= stack[depth-1], restoring all bits including sticky ones.
  - depth-1.
  - write and clr_sticky are ignored that cycle.
- Overflow (push while full): stack and depth unchanged; err<=1; write applies normally.
- Underflow (pop while empty): depth unchanged; flags take the normal write/clr result; err<=1.
- Conflict (push and pop same cycle): no stack operation; flags take the normal write/clr result; err<=1.
- err is sticky. It is cleared only by clr_err or reset. If an error event coincides with clr_err, err stays 1 (set wins).
- full/empty are decoded combinationally from the depth register.
- Width rules:
  - STACK_DEPTH=1 is legal; depth is 1 bit.
  - depth never exceeds STACK_DEPTH and never wraps.

Decomposition:
- Shared package flag_pkg:
  - Flag index constants FLAG_Z=0, FLAG_V=1, FLAG_N=2.
  - Default NUM_FLAGS=3.
  - Depth-width function clog2.
- One sub-module, flag_stack:
  - LIFO storage array with depth counter, push/pop/full/empty.
  - Parametrised by WIDTH=NUM_FLAGS and STACK_DEPTH.
  - Clocked on clk with the same asynchronous active-low reset.
- flag_file owns the flag register, sticky logic, error logic and operation arbitration.

Test Plan:
- Reset, then write=3'b111, in=3'b101 → next cycle flag_out=101. Then write=3'b010, in=3'b010 → flag_out=111.
- Sticky, with STICKY_MASK=3'b010 and flag V set:
  - write=3'b010, in=000 → V stays 1.
  - clr_sticky=1 → V=0.
  - clr_sticky=1 with write=010, in=010 → V=1.
- Save/restore:
  - flags=001; push with write=111, in=110 → flag_out=110, depth=1.
  - pop with write=111, in=000 → flag_out=001, depth=0, empty=1.
- Overflow, with STACK_DEPTH=4:
  - five pushes with flags 000..100 → depth=4, full=1, err=1.
  - four pops return 011, 010, 001, 000.
  - fifth pop → err stays 1, flags unchanged, depth=0.
- Conflict: push=1 and pop=1 with depth=2 → depth=2, err=1. clr_err=1 next cycle → err=0.
- Asynchronous reset: assert rst=0 mid-cycle while depth=3, flags=111 → flag_out=0, depth=0, err=0 immediately, without waiting for a clk edge.
